pb_key_event_encoder: RTL
=========================

# pb_key_event_encoder

Front-end stage sitting between the breakout-board pushbutton pins and the synth core's note logic. Synchronises the 15 raw pushbuttons, debounces each on a shared sample tick, and converts accepted level changes into key events. Events are queued in a small FIFO and presented on a valid/ready interface, so the downstream note/voice logic never sees bounce or misses simultaneous presses.

## Interface
- NUM_PB, 15, number of pushbuttons (key_code width fixed at 4, so NUM_PB ≤ 16)
- DB_TICK_DIV, 1000, hwclk cycles per debounce sample tick (≥ NUM_PB+2)
- DB_SAMPLES, 4, consecutive differing samples needed to accept a change (≥ 2)
- FIFO_DEPTH, 4, event queue entries (power of 2)

- hwclk  in  1  system clock
- r_eset  in  1  synchronous, active-high reset
- pb  in  NUM_PB  raw asynchronous pushbutton levels, 1 = pressed
- key_valid  out  1  FIFO head holds an event
- key_ready  in  1  consumer accepts head this cycle
- key_code  out  4  button index 0..NUM_PB-1 of head event
- key_press  out  1  1 = press, 0 = release
- key_held  out  NUM_PB  debounced button levels
- overflow  out  1  sticky: an event was lost

## Operation
- Reset: all sync flops, prescaler, debounce counters, pending bits and FIFO pointers cleared. key_valid=0, key_code=0, key_press=0, key_held=0, overflow=0.
- Sync: 2-flop synchroniser per bit. The result is s_pb.
- Prescaler: counts 0..DB_TICK_DIV-1 and wraps to 0. tick=1 for one cycle when the count equals DB_TICK_DIV-1.
- Per-button debounce, evaluated only on tick:
  - If s_pb[i]==key_held[i], the counter clears.
  - Otherwise the counter increments. When it would reach DB_SAMPLES, the change is accepted: key_held[i] toggles, the counter clears, and pending[i] is set with pending_dir[i]=new level.
- Arbiter: each cycle, picks the lowest i with pending[i]=1.
  - If the FIFO can accept, it pushes {i, pending_dir[i]} and clears pending[i].
  - The FIFO can accept when not full, or when full and popping this cycle.
  - A full FIFO stalls pending events; they are never dropped for this reason.
- Collision: if a button is accepted again while its pending bit is still set, the new event overwrites the old one and overflow sets. overflow clears only on r_eset.
- FIFO:
  - key_valid = not empty. key_code and key_press are driven from the head entry.
  - Pop occurs when key_valid && key_ready. key_ready while empty is ignored.
  - Head outputs hold while key_valid=1 and key_ready=0.
- Events come out in acceptance order. Events accepted on the same tick come out in ascending index order.
- Reset mid-operation: everything clears. Buttons held through reset are re-accepted as presses after debounce.

## Timing
- Acceptance at tick cycle T:
  - key_held and pending update at T+1.
  - The push happens at the end of T+1 if the FIFO is empty.
  - key_valid=1 at T+2.
- Worst-case latency from a stable pb edge to key_valid: 2 + DB_TICK_DIV·DB_SAMPLES + 2 cycles.
- Bounce shorter than DB_SAMPLES ticks produces no event and no key_held change.
- k buttons accepted on the same tick enqueue on consecutive cycles T+1..T+k. DB_TICK_DIV ≥ NUM_PB+2 guarantees the pending bits drain before the next tick when the FIFO has room.
- Simultaneous push and pop: the FIFO occupancy is unchanged, including when full.

## Configuration
- PB_RELEASE_EVENTS_EN defined: both press and release acceptances enqueue events.
- PB_RELEASE_EVENTS_EN undefined:
  - A release updates key_held and clears its counter but sets no pending bit.
  - Only press events are queued, and key_press is always 1 when key_valid=1 (0 in reset).

## Test plan
Benches use DB_TICK_DIV=4, DB_SAMPLES=3, FIFO_DEPTH=4, key_ready=1 unless stated.
- Clean press of pb[5] held 40 cycles → one event {key_code=5, key_press=1} within 18 cycles of the edge; key_held[5]=1; overflow=0.
- pb[2] toggling every 5 cycles for 60 cycles, then held high → no event during the bounce; exactly one press after it settles.
- pb[0], pb[7], pb[14] rising in the same cycle → three events on consecutive cycles with codes 0, 7, 14 in that order.
- key_ready=0 while 6 separate presses occur → the FIFO holds 4 events, key_valid stays 1, and the remaining 2 stay pending with overflow=0. Raising key_ready drains all 6 in acceptance order.
- With PB_RELEASE_EVENTS_EN, press then release of pb[9] → {9,1} then {9,0}. Without the macro → only {9,1}, and key_held[9] returns to 0.
- r_eset asserted for 1 cycle with 2 queued events and pb[3] held → key_valid=0 next cycle and key_held=0. After debounce, one {3,1} event appears.

Source files
------------

// File: rtl/pb_key_event_encoder.sv
// pb_key_event_encoder: synchronises and debounces NUM_PB pushbuttons on a
// shared sample tick and queues accepted level changes as key events in a
// small FIFO presented on a valid/ready interface.
// Optional feature macro: PB_RELEASE_EVENTS_EN (queue release events too;
// when undefined only presses are queued and releases just update key_held).
module pb_key_event_encoder #(
    parameter int NUM_PB      = 15,
    parameter int DB_TICK_DIV = 1000,
    parameter int DB_SAMPLES  = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              hwclk,
    input  logic              r_eset,
    input  logic [NUM_PB-1:0] pb,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [3:0]        key_code,
    output logic              key_press,
    output logic [NUM_PB-1:0] key_held,
    output logic              overflow
);

`ifdef PB_RELEASE_EVENTS_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    localparam int PW = (DB_TICK_DIV > 1) ? $clog2(DB_TICK_DIV) : 1;
    localparam int CW = $clog2(DB_SAMPLES + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    localparam logic [PW-1:0] TICK_LAST = PW'(DB_TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DB_SAMPLES - 1);
    localparam logic [NW-1:0] FIFO_FULL = NW'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_LAST  = AW'(FIFO_DEPTH - 1);

    // state registers
    logic [NUM_PB-1:0] sync1_q, sync1_d;
    logic [NUM_PB-1:0] sync2_q, sync2_d;   // s_pb
    logic [PW-1:0]     presc_q, presc_d;
    logic [CW-1:0]     cnt_q [NUM_PB];
    logic [CW-1:0]     cnt_d [NUM_PB];
    logic [NUM_PB-1:0] held_q, held_d;
    logic [NUM_PB-1:0] pend_q, pend_d;
    logic [NUM_PB-1:0] pdir_q, pdir_d;
    logic              ovf_q, ovf_d;
    logic [4:0]        mem_q [FIFO_DEPTH];
    logic [4:0]        mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [NW-1:0]     count_q, count_d;
    logic              key_valid_q, key_valid_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_press_q, key_press_d;

    // combinational helpers
    logic              tick_s;
    logic              pop_s;
    logic              found_s;
    logic [3:0]        sel_s;
    logic              push_s;
    logic [4:0]        head_s;

    // Next-state logic: sync, prescaler, debounce, arbiter and FIFO
    always_comb begin
        sync1_d     = pb;
        sync2_d     = sync1_q;
        presc_d     = presc_q;
        held_d      = held_q;
        pend_d      = pend_q;
        pdir_d      = pdir_q;
        ovf_d       = ovf_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        count_d     = count_q;
        found_s     = 1'b0;
        sel_s       = 4'd0;
        head_s      = 5'd0;
        key_valid_d = 1'b0;
        key_code_d  = 4'd0;
        key_press_d = 1'b0;
        for (int i = 0; i < NUM_PB; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int j = 0; j < FIFO_DEPTH; j++) begin
            mem_d[j] = mem_q[j];
        end

        tick_s = (presc_q == TICK_LAST);
        if (tick_s) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        pop_s = key_valid_q && key_ready;

        // Lowest pending index wins: scan downwards so the last hit is lowest.
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                found_s = 1'b1;
                sel_s   = 4'(i);
            end else begin
                found_s = found_s;
            end
        end

        // A full FIFO that is popping this cycle still has room for one push.
        push_s = found_s && ((count_q != FIFO_FULL) || pop_s);
        if (push_s) begin
            pend_d[sel_s] = 1'b0;
            mem_d[wr_q]   = {sel_s, pdir_q[sel_s]};
            wr_d          = (wr_q == PTR_LAST) ? '0 : wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end

        if (pop_s) begin
            rd_d = (rd_q == PTR_LAST) ? '0 : rd_q + AW'(1);
        end else begin
            rd_d = rd_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + NW'(1);
            2'b01:   count_d = count_q - NW'(1);
            default: count_d = count_q;
        endcase

        // Debounce: a new acceptance sets pending after the arbiter's clear,
        // so it is never lost; it only counts as a collision when the old
        // event is still sitting in pending and is not leaving this cycle.
        for (int i = 0; i < NUM_PB; i++) begin
            if (tick_s) begin
                if (sync2_q[i] == held_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    held_d[i] = ~held_q[i];
                    cnt_d[i]  = '0;
                    if (REL_EN || !held_q[i]) begin
                        if (pend_q[i] && !(push_s && (sel_s == 4'(i)))) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_d;
                        end
                        pend_d[i] = 1'b1;
                        pdir_d[i] = ~held_q[i];
                    end else begin
                        pend_d[i] = pend_d[i];
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end

        // Outputs are registered from the next head entry.
        key_valid_d = (count_d != '0);
        head_s      = mem_d[rd_d];
        if (key_valid_d) begin
            key_code_d  = head_s[4:1];
            key_press_d = head_s[0];
        end else begin
            key_code_d  = 4'd0;
            key_press_d = 1'b0;
        end
    end

    // State update with synchronous active-high reset
    always_ff @(posedge hwclk) begin
        if (r_eset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            presc_q     <= '0;
            held_q      <= '0;
            pend_q      <= '0;
            pdir_q      <= '0;
            ovf_q       <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
            key_press_q <= 1'b0;
            for (int i = 0; i < NUM_PB; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= 5'd0;
            end
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            presc_q     <= presc_d;
            held_q      <= held_d;
            pend_q      <= pend_d;
            pdir_q      <= pdir_d;
            ovf_q       <= ovf_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_press_q <= key_press_d;
            for (int i = 0; i < NUM_PB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= mem_d[j];
            end
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_press = key_press_q;
    assign key_held  = held_q;
    assign overflow  = ovf_q;

endmodule
